keypad_entry: RTL and testbench
===============================

Name: keypad_entry

Overview:
- Consumes the 5-bit scanned key code from the keypad scanner on the 48 MHz system clock.
- Debounces press and release, emits one press event per physical press, and assembles a decimal number entry of up to DIGITS digits.
- '*' clears the entry; '#' commits it. The committed value and live entry digits feed the video overlay and the blaster control logic (for example, a current setpoint or arm code).

Parameters:
DEBOUNCE_CYCLES, 48000, cycles a code must be stable to be accepted (1 ms at 48 MHz)
TIMEOUT_CYCLES, 480000000, idle cycles after the last accepted press before a partial entry auto-clears (10 s)
DIGITS, 4, maximum digits held in the entry buffer

Ports:
clk  in  1  48 MHz system clock
reset  in  1  asynchronous active-high reset
key  in  5  scanner code: 0x00 none; 0x10 digit 0; 0x11-0x19 digits 1-9; 0x1A '*'; 0x1B '#'; other values invalid
key_valid  out  1  one-cycle pulse on accepted press
key_code  out  5  code of the accepted press; held until the next press
entry_bcd  out  4*DIGITS  live entry, BCD, least significant digit in [3:0]
entry_len  out  3  digits currently entered (0..DIGITS)
commit  out  1  one-cycle pulse when a '#' commit's binary result is ready
value  out  14  committed binary value; held until the next commit
overflow  out  1  sticky; set when a digit is pressed with a full buffer; cleared by '*', commit, or timeout

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM in IDLE, counters 0.
- Input sampling: key is registered twice before use. Decisions use the registered value k.
- Debounce FSM states:
  - IDLE: k != 0 → load cand=k, cnt=0, go to PRESS_DB.
  - PRESS_DB: k != cand → back to IDLE. Otherwise cnt++. When cnt == DEBOUNCE_CYCLES-1 → go to HELD and pulse key_valid if cand is valid (0x10-0x1B). Invalid codes are swallowed silently.
  - HELD: k == 0 → cnt=0, go to REL_DB. k changing to another nonzero code does not produce a new event.
  - REL_DB: k != 0 → back to HELD. When cnt == DEBOUNCE_CYCLES-1 → go to IDLE.
- Holding a key never repeats. Exactly one key_valid per press.
- key_valid timing: asserts on the cycle after the DEBOUNCE_CYCLES-th consecutive stable registered sample. key_code updates in the same cycle.
- Entry actions on key_valid:
  - Digit, entry_len < DIGITS: shift entry_bcd left 4 bits, insert the digit at [3:0], entry_len++.
  - Digit, entry_len == DIGITS: buffer unchanged, overflow=1.
  - '*': entry_bcd=0, entry_len=0, overflow=0.
  - '#' with entry_len == 0: ignored. No commit, value unchanged.
  - '#' with entry_len > 0: start sequential BCD-to-binary conversion.
- Conversion sub-FSM (CONV):
  - acc=0. For i from entry_len-1 down to 0: acc = acc*10 + digit[i], one digit per cycle.
  - acc*10 is computed as (acc<<3)+(acc<<1), 14-bit. Maximum 9999 fits, so no wrap.
  - After the last digit: value=acc, commit pulses for one cycle, entry cleared, overflow=0.
  - Latency from the '#' key_valid to commit is entry_len+1 cycles.
  - key_valid events arriving during CONV are ignored. This cannot occur in practice, given debounce length.
- Timeout: counter resets on every key_valid and counts while entry_len > 0. At TIMEOUT_CYCLES it clears entry_bcd, entry_len and overflow. value is untouched.
  - If the timeout and a key_valid land in the same cycle, the key wins: the counter restarts and the key is applied.
- Reset mid-debounce or mid-conversion: everything returns to reset values immediately. No commit pulse is issued.

Decomposition:
- Shared package keypad_pkg:
  - key code localparams: KEY_NONE=5'h00, KEY_D0=5'h10, KEY_STAR=5'h1A, KEY_HASH=5'h1B;
  - function is_digit(code) and function digit_of(code);
  - enum typedef for debounce states {IDLE, PRESS_DB, HELD, REL_DB}.
- Sub-module key_debounce: the synchronizer, debounce FSM, key_valid and key_code.
- keypad_entry instantiates key_debounce and holds the entry buffer, conversion and timeout logic.

Test Plan:
- Press 0x13 (digit 3) stable for DEBOUNCE_CYCLES, then 0x00 → exactly one key_valid, key_code=0x13, entry_bcd=0x0003, entry_len=1.
- 0x15 glitching for DEBOUNCE_CYCLES/2, then 0x00 → no key_valid. Holding 0x15 for 5×DEBOUNCE_CYCLES → a single key_valid.
- Digits 1,2,3,4, then '#' → commit pulses 5 cycles after the '#' key_valid, value=1234, entry_len=0.
- Digits 9,9,9,9,7 → 5th digit sets overflow=1 with entry_bcd=0x9999. Then '#' → value=9999, overflow=0.
- Digits 4,2, then '*' → entry_bcd=0, entry_len=0. '#' with an empty entry → no commit, value keeps its previous value.
- Digit 5, then idle for TIMEOUT_CYCLES (bench overrides it to 1000) → entry clears. Assert reset during CONV → all outputs 0, no commit.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, decode helpers and debounce state type for the keypad entry block.
package keypad_pkg;

  localparam logic [4:0] KEY_NONE = 5'h00;
  localparam logic [4:0] KEY_D0   = 5'h10;
  localparam logic [4:0] KEY_STAR = 5'h1A;
  localparam logic [4:0] KEY_HASH = 5'h1B;

  localparam int VALUE_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } db_state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return (code >= KEY_D0) && (code <= 5'h19);
  endfunction

  function automatic logic is_key(input logic [4:0] code);
    return (code >= KEY_D0) && (code <= KEY_HASH);
  endfunction

  function automatic logic [3:0] digit_of(input logic [4:0] code);
    return 4'(code - KEY_D0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-stage input synchronizer and press/release debounce; one key_valid per physical press.
//
// state    | meaning
// IDLE     | no key seen, waiting for a nonzero code
// PRESS_DB | candidate code must stay stable DEBOUNCE_CYCLES samples
// HELD     | press accepted; waiting for release, code changes ignored
// REL_DB   | zero code must stay stable DEBOUNCE_CYCLES samples
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] key,
  output logic       key_valid,
  output logic [4:0] key_code
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        state, state_nxt;
  logic [4:0]       k_meta, k;
  logic [4:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k_meta    <= '0;
      k         <= '0;
      cand      <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      state     <= state_nxt;
      k_meta    <= key;
      k         <= k_meta;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      key_valid <= fire && is_key(cand);
      if (fire && is_key(cand))
        key_code <= cand;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (k != KEY_NONE) begin
          cand_nxt  = k;
          cnt_nxt   = '0;
          state_nxt = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (k != cand)
          state_nxt = IDLE;
        else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          fire      = 1'b1;
        end else
          cnt_nxt = cnt + 1'b1;
      end
      HELD: begin
        if (k == KEY_NONE) begin
          cnt_nxt   = '0;
          state_nxt = REL_DB;
        end
      end
      REL_DB: begin
        if (k != KEY_NONE)
          state_nxt = HELD;
        else if (cnt == CNT_LAST)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: debounced keys build a BCD buffer, '#' converts it to binary, '*' or idle timeout clears.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int TIMEOUT_CYCLES  = 480000000,
  parameter int DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            key,
  output logic                  key_valid,
  output logic [4:0]            key_code,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic [2:0]            entry_len,
  output logic                  commit,
  output logic [VALUE_W-1:0]    value,
  output logic                  overflow
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LEN_MAX  = 3'(DIGITS);

  logic               busy;
  logic [IDX_W-1:0]   conv_idx;
  logic [VALUE_W-1:0] acc, acc_next;
  logic [3:0]         cur_digit;
  logic [TMO_W-1:0]   tmo_cnt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  // Most significant digit first; acc*10 as two shifts keeps this adder-only.
  always_comb begin
    cur_digit = entry_bcd[{conv_idx, 2'b00} +: 4];
    acc_next  = (acc << 3) + (acc << 1) + VALUE_W'(cur_digit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_bcd <= '0;
      entry_len <= '0;
      overflow  <= 1'b0;
      value     <= '0;
      commit    <= 1'b0;
      busy      <= 1'b0;
      conv_idx  <= '0;
      acc       <= '0;
      tmo_cnt   <= '0;
    end else begin
      commit <= 1'b0;
      if (busy) begin
        acc <= acc_next;
        if (conv_idx == '0) begin
          busy      <= 1'b0;
          value     <= acc_next;
          commit    <= 1'b1;
          entry_bcd <= '0;
          entry_len <= '0;
          overflow  <= 1'b0;
        end else
          conv_idx <= conv_idx - 1'b1;
      end else if (key_valid) begin
        tmo_cnt <= TMO_LOAD;
        if (is_digit(key_code)) begin
          if (entry_len < LEN_MAX) begin
            entry_bcd <= {entry_bcd[4*DIGITS-5:0], digit_of(key_code)};
            entry_len <= entry_len + 1'b1;
          end else
            overflow <= 1'b1;
        end else if (key_code == KEY_STAR) begin
          entry_bcd <= '0;
          entry_len <= '0;
          overflow  <= 1'b0;
        end else if (key_code == KEY_HASH && entry_len != '0) begin
          busy     <= 1'b1;
          acc      <= '0;
          conv_idx <= IDX_W'(entry_len - 3'd1);
        end
      end else if (entry_len != '0) begin
        if (tmo_cnt == '0) begin
          entry_bcd <= '0;
          entry_len <= '0;
          overflow  <= 1'b0;
        end else
          tmo_cnt <= tmo_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with shortened debounce and timeout.
module tb_keypad_entry;

  localparam int DB  = 16;
  localparam int TO  = 1000;
  localparam int REL = 3 * DB;

  logic        clk;
  logic        reset;
  logic [4:0]  key;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_len;
  logic        commit;
  logic [13:0] value;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int kv_cnt   = 0;
  int kv_cyc   = 0;
  int cm_cnt   = 0;
  int cm_cyc   = 0;

  keypad_entry #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .DIGITS         (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .key_valid(key_valid),
    .key_code (key_code),
    .entry_bcd(entry_bcd),
    .entry_len(entry_len),
    .commit   (commit),
    .value    (value),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset && key_valid) begin
      kv_cnt <= kv_cnt + 1;
      kv_cyc <= cyc;
    end
    if (!reset && commit) begin
      cm_cnt <= cm_cnt + 1;
      cm_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic press_key(input logic [4:0] code, input int hold);
    key = code;
    repeat (hold) @(negedge clk);
    key = 5'h00;
    repeat (REL) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_kv"},    32'(key_valid), 32'h0);
    check({tag, "_code"},  32'(key_code),  32'h0);
    check({tag, "_bcd"},   32'(entry_bcd), 32'h0);
    check({tag, "_len"},   32'(entry_len), 32'h0);
    check({tag, "_cmt"},   32'(commit),    32'h0);
    check({tag, "_value"}, 32'(value),     32'h0);
    check({tag, "_ovf"},   32'(overflow),  32'h0);
  endtask

  initial begin
    int kv0, cm0, wait_n;
    logic [4:0] seq_a [5];
    logic [4:0] seq_b [5];
    seq_a = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h1B};
    seq_b = '{5'h19, 5'h19, 5'h19, 5'h19, 5'h17};

    reset = 1'b1;
    key   = 5'h00;
    repeat (4) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // single clean press of digit 3
    kv0 = kv_cnt;
    press_key(5'h13, 3 * DB);
    check("d3_kv_count", 32'(kv_cnt - kv0), 32'd1);
    check("d3_code",     32'(key_code),     32'h13);
    check("d3_bcd",      32'(entry_bcd),    32'h0003);
    check("d3_len",      32'(entry_len),    32'd1);

    // short glitch is rejected, long hold gives one event
    kv0 = kv_cnt;
    press_key(5'h15, DB / 2);
    check("glitch_kv_count", 32'(kv_cnt - kv0), 32'd0);
    check("glitch_len",      32'(entry_len),    32'd1);
    kv0 = kv_cnt;
    press_key(5'h15, 5 * DB);
    check("hold_kv_count", 32'(kv_cnt - kv0), 32'd1);
    check("hold_bcd",      32'(entry_bcd),    32'h0035);

    // invalid code is swallowed
    kv0 = kv_cnt;
    press_key(5'h1F, 3 * DB);
    check("invalid_kv_count", 32'(kv_cnt - kv0), 32'd0);
    check("invalid_code",     32'(key_code),      32'h15);

    press_key(5'h1A, 3 * DB);
    check("star_len", 32'(entry_len), 32'd0);

    // 1234#
    cm0 = cm_cnt;
    foreach (seq_a[i]) press_key(seq_a[i], 3 * DB);
    check("c1234_commits", 32'(cm_cnt - cm0),  32'd1);
    check("c1234_latency", 32'(cm_cyc - kv_cyc), 32'd5);
    check("c1234_value",   32'(value),         32'd1234);
    check("c1234_len",     32'(entry_len),     32'd0);
    check("c1234_bcd",     32'(entry_bcd),     32'h0);

    // 99997 overflows, then # commits 9999
    foreach (seq_b[i]) press_key(seq_b[i], 3 * DB);
    check("ovf_flag", 32'(overflow),  32'd1);
    check("ovf_bcd",  32'(entry_bcd), 32'h9999);
    check("ovf_len",  32'(entry_len), 32'd4);
    press_key(5'h1B, 3 * DB);
    check("c9999_value", 32'(value),    32'd9999);
    check("c9999_ovf",   32'(overflow), 32'd0);

    // 42 then * clears; # on empty does nothing
    press_key(5'h14, 3 * DB);
    press_key(5'h12, 3 * DB);
    check("d42_bcd", 32'(entry_bcd), 32'h0042);
    press_key(5'h1A, 3 * DB);
    check("clr_bcd", 32'(entry_bcd), 32'h0);
    check("clr_len", 32'(entry_len), 32'd0);
    cm0 = cm_cnt;
    press_key(5'h1B, 3 * DB);
    check("empty_hash_commits", 32'(cm_cnt - cm0), 32'd0);
    check("empty_hash_value",   32'(value),        32'd9999);

    // idle timeout clears a partial entry, value untouched
    press_key(5'h15, 3 * DB);
    repeat (800) @(negedge clk);
    check("tmo_before_len", 32'(entry_len), 32'd1);
    repeat (200) @(negedge clk);
    check("tmo_after_len",   32'(entry_len), 32'd0);
    check("tmo_after_bcd",   32'(entry_bcd), 32'h0);
    check("tmo_after_value", 32'(value),     32'd9999);

    // reset in the middle of a conversion
    press_key(5'h11, 3 * DB);
    press_key(5'h12, 3 * DB);
    cm0 = cm_cnt;
    key = 5'h1B;
    wait_n = 0;
    while (!key_valid && wait_n < 4 * DB) begin
      @(negedge clk);
      wait_n++;
    end
    check("conv_hash_seen", 32'(key_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    key   = 5'h00;
    #1;
    check_outputs_zero("conv_reset");
    repeat (6) @(negedge clk);
    check("conv_reset_commits", 32'(cm_cnt - cm0), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_len", 32'(entry_len), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
